// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer constants
package rob_pkg;
    localparam int ROB_WIDTH_DEFAULT = 4;

    localparam logic [1:0] ROB_TYPE_REG = 2'd0;
    localparam logic [1:0] ROB_TYPE_BR  = 2'd1;
    localparam logic [1:0] ROB_TYPE_ST  = 2'd2;
endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement with write-back forwarding and misprediction flush
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_signal,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd_id,
    input  logic [31:0]          issue_pred_pc,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rob_full,
    input  logic [ROB_WIDTH-1:0] query_tag_1,
    input  logic [ROB_WIDTH-1:0] query_tag_2,
    output logic                 query_ready_1,
    output logic                 query_ready_2,
    output logic [31:0]          query_value_1,
    output logic [31:0]          query_value_2,
    input  logic                 wb_signal,
    input  logic [ROB_WIDTH-1:0] wb_tag,
    input  logic [31:0]          wb_value,
    input  logic [31:0]          wb_next_pc,
    output logic                 commit_signal,
    output logic [31:0]          commit_rd_value,
    output logic [4:0]           commit_rd_id,
    output logic [ROB_WIDTH-1:0] commit_rd_tag,
    output logic                 commit_store_signal,
    output logic                 clear_signal,
    output logic [31:0]          clear_pc
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);

    logic        busy    [DEPTH];
    logic        ready   [DEPTH];
    logic [1:0]  etype   [DEPTH];
    logic [4:0]  rd_id   [DEPTH];
    logic [31:0] value   [DEPTH];
    logic [31:0] pred_pc [DEPTH];
    logic [31:0] next_pc [DEPTH];

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    logic        issue_fire;
    logic        wb_fire;
    logic        head_wb;
    logic        commit_fire;
    logic        mispredict;
    logic [31:0] head_value;
    logic [31:0] head_next_pc;
    logic        q1_wb;
    logic        q2_wb;

    assign rob_full   = (count == FULL_COUNT);
    assign issue_tag  = tail;
    assign issue_fire = rdy_in & issue_signal & ~rob_full & ~clear_signal;
    assign wb_fire    = rdy_in & wb_signal & busy[wb_tag];

    // Forward a same-cycle write-back into the head so retirement costs no extra cycle.
    assign head_wb      = wb_fire & (wb_tag == head);
    assign head_value   = head_wb ? wb_value : value[head];
    assign head_next_pc = head_wb ? wb_next_pc : next_pc[head];
    assign commit_fire  = rdy_in & (count != '0) & (ready[head] | head_wb);
    assign mispredict   = commit_fire & (etype[head] == ROB_TYPE_BR)
                        & (head_next_pc != pred_pc[head]);

    assign q1_wb         = wb_fire & (wb_tag == query_tag_1);
    assign q2_wb         = wb_fire & (wb_tag == query_tag_2);
    assign query_ready_1 = busy[query_tag_1] & (ready[query_tag_1] | q1_wb);
    assign query_ready_2 = busy[query_tag_2] & (ready[query_tag_2] | q2_wb);
    assign query_value_1 = q1_wb ? wb_value : value[query_tag_1];
    assign query_value_2 = q2_wb ? wb_value : value[query_tag_2];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            commit_signal       <= 1'b0;
            commit_rd_value     <= '0;
            commit_rd_id        <= '0;
            commit_rd_tag       <= '0;
            commit_store_signal <= 1'b0;
            clear_signal        <= 1'b0;
            clear_pc            <= '0;
            for (int i = 0; i < DEPTH; i++) busy[i] <= 1'b0;
        end else if (rdy_in) begin
            commit_signal       <= commit_fire;
            commit_store_signal <= commit_fire & (etype[head] == ROB_TYPE_ST);
            clear_signal        <= mispredict;
            if (commit_fire) begin
                commit_rd_value <= head_value;
                commit_rd_id    <= rd_id[head];
                commit_rd_tag   <= head;
            end
            if (mispredict) clear_pc <= head_next_pc;

            if (wb_fire) begin
                ready[wb_tag]   <= 1'b1;
                value[wb_tag]   <= wb_value;
                next_pc[wb_tag] <= wb_next_pc;
            end
            if (issue_fire) begin
                busy[tail]    <= 1'b1;
                ready[tail]   <= 1'b0;
                etype[tail]   <= issue_type;
                rd_id[tail]   <= (issue_type == ROB_TYPE_ST) ? 5'd0 : issue_rd_id;
                pred_pc[tail] <= issue_pred_pc;
            end
            if (commit_fire) busy[head] <= 1'b0;

            // A flush discards everything behind the branch, including a same-cycle issue.
            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++) busy[i] <= 1'b0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + ROB_WIDTH'(commit_fire);
                tail  <= tail + ROB_WIDTH'(issue_fire);
                count <= count + (ROB_WIDTH + 1)'(issue_fire) - (ROB_WIDTH + 1)'(commit_fire);
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed vector bench for reorder_buffer
module tb_reorder_buffer;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        issue_signal;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd_id;
    logic [31:0] issue_pred_pc;
    logic [3:0]  issue_tag;
    logic        rob_full;
    logic [3:0]  query_tag_1, query_tag_2;
    logic        query_ready_1, query_ready_2;
    logic [31:0] query_value_1, query_value_2;
    logic        wb_signal;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value, wb_next_pc;
    logic        commit_signal;
    logic [31:0] commit_rd_value;
    logic [4:0]  commit_rd_id;
    logic [3:0]  commit_rd_tag;
    logic        commit_store_signal;
    logic        clear_signal;
    logic [31:0] clear_pc;

    int total = 0;
    int bad   = 0;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_signal(issue_signal), .issue_type(issue_type), .issue_rd_id(issue_rd_id),
        .issue_pred_pc(issue_pred_pc), .issue_tag(issue_tag), .rob_full(rob_full),
        .query_tag_1(query_tag_1), .query_tag_2(query_tag_2),
        .query_ready_1(query_ready_1), .query_ready_2(query_ready_2),
        .query_value_1(query_value_1), .query_value_2(query_value_2),
        .wb_signal(wb_signal), .wb_tag(wb_tag), .wb_value(wb_value), .wb_next_pc(wb_next_pc),
        .commit_signal(commit_signal), .commit_rd_value(commit_rd_value),
        .commit_rd_id(commit_rd_id), .commit_rd_tag(commit_rd_tag),
        .commit_store_signal(commit_store_signal),
        .clear_signal(clear_signal), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        iss;
        logic [1:0]  ityp;
        logic [4:0]  ird;
        logic [31:0] ipc;
        logic        wb;
        logic [3:0]  wtag;
        logic [31:0] wval;
        logic [31:0] wnpc;
        logic [3:0]  qtag;
        logic        e_qrdy;
        logic [31:0] e_qval;
        logic [3:0]  e_itag;
        logic        e_cs;
        logic [4:0]  e_crd;
        logic [31:0] e_cval;
        logic [3:0]  e_ctag;
        logic        e_st;
        logic        e_clr;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(
        logic iss, logic [1:0] ityp, logic [4:0] ird, logic [31:0] ipc,
        logic wb, logic [3:0] wtag, logic [31:0] wval, logic [31:0] wnpc,
        logic [3:0] qtag, logic e_qrdy, logic [31:0] e_qval, logic [3:0] e_itag,
        logic e_cs, logic [4:0] e_crd, logic [31:0] e_cval, logic [3:0] e_ctag,
        logic e_st, logic e_clr);
        vec_t v;
        v.iss = iss; v.ityp = ityp; v.ird = ird; v.ipc = ipc;
        v.wb = wb; v.wtag = wtag; v.wval = wval; v.wnpc = wnpc;
        v.qtag = qtag; v.e_qrdy = e_qrdy; v.e_qval = e_qval; v.e_itag = e_itag;
        v.e_cs = e_cs; v.e_crd = e_crd; v.e_cval = e_cval; v.e_ctag = e_ctag;
        v.e_st = e_st; v.e_clr = e_clr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_signal = 1'b0; issue_type = 2'd0; issue_rd_id = 5'd0; issue_pred_pc = 32'd0;
        wb_signal = 1'b0; wb_tag = 4'd0; wb_value = 32'd0; wb_next_pc = 32'd0;
        query_tag_1 = 4'd0; query_tag_2 = 4'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc);
        issue_signal = 1'b1; issue_type = t; issue_rd_id = rd; issue_pred_pc = pc;
        tick();
        idle();
    endtask

    task automatic wb(input logic [3:0] tag, input logic [31:0] val, input logic [31:0] npc);
        wb_signal = 1'b1; wb_tag = tag; wb_value = val; wb_next_pc = npc;
        tick();
        idle();
    endtask

    task automatic apply(input vec_t v, input int idx);
        issue_signal = v.iss; issue_type = v.ityp; issue_rd_id = v.ird; issue_pred_pc = v.ipc;
        wb_signal = v.wb; wb_tag = v.wtag; wb_value = v.wval; wb_next_pc = v.wnpc;
        query_tag_1 = v.qtag;
        #1;
        chk($sformatf("v%0d issue_tag", idx), 32'(issue_tag), 32'(v.e_itag));
        chk($sformatf("v%0d query_ready", idx), 32'(query_ready_1), 32'(v.e_qrdy));
        if (v.e_qrdy) chk($sformatf("v%0d query_value", idx), query_value_1, v.e_qval);
        tick();
        chk($sformatf("v%0d commit_signal", idx), 32'(commit_signal), 32'(v.e_cs));
        if (v.e_cs) begin
            chk($sformatf("v%0d commit_rd_id", idx), 32'(commit_rd_id), 32'(v.e_crd));
            chk($sformatf("v%0d commit_rd_value", idx), commit_rd_value, v.e_cval);
            chk($sformatf("v%0d commit_rd_tag", idx), 32'(commit_rd_tag), 32'(v.e_ctag));
            chk($sformatf("v%0d commit_store", idx), 32'(commit_store_signal), 32'(v.e_st));
        end
        chk($sformatf("v%0d clear_signal", idx), 32'(clear_signal), 32'(v.e_clr));
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rdy_in = 1'b1;
        idle();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst issue_tag", 32'(issue_tag), 0);
        chk("rst rob_full", 32'(rob_full), 0);
        chk("rst commit_signal", 32'(commit_signal), 0);
        chk("rst commit_rd_value", commit_rd_value, 0);
        chk("rst commit_rd_id", 32'(commit_rd_id), 0);
        chk("rst commit_store", 32'(commit_store_signal), 0);
        chk("rst clear_signal", 32'(clear_signal), 0);
        chk("rst clear_pc", clear_pc, 0);

        // In-flight entry discarded by reset, even with a write-back in the same cycle.
        issue(2'd0, 5'd6, 32'd0);
        wb_signal = 1'b1; wb_tag = 4'd0; wb_value = 32'h55;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        idle();
        chk("rst_flight commit_signal", 32'(commit_signal), 0);
        chk("rst_flight issue_tag", 32'(issue_tag), 0);
        #1;
        chk("rst_flight query_ready", 32'(query_ready_1), 0);

        vt[0]  = mk(1,0,5,0,          0,0,0,0,             0, 0,0,       0, 0,0,0,0,0,0);
        vt[1]  = mk(0,0,0,0,          1,0,32'h1234,0,      0, 1,32'h1234,1, 1,5,32'h1234,0,0,0);
        vt[2]  = mk(1,0,1,0,          0,0,0,0,             5, 0,0,       1, 0,0,0,0,0,0);
        vt[3]  = mk(1,0,2,0,          0,0,0,0,             1, 0,0,       2, 0,0,0,0,0,0);
        vt[4]  = mk(1,0,3,0,          0,0,0,0,             0, 0,0,       3, 0,0,0,0,0,0);
        vt[5]  = mk(0,0,0,0,          1,3,32'h33,0,        3, 1,32'h33,  4, 0,0,0,0,0,0);
        vt[6]  = mk(0,0,0,0,          1,2,32'h22,0,        3, 1,32'h33,  4, 0,0,0,0,0,0);
        vt[7]  = mk(0,0,0,0,          1,1,32'h11,0,        1, 1,32'h11,  4, 1,1,32'h11,1,0,0);
        vt[8]  = mk(0,0,0,0,          0,0,0,0,             2, 1,32'h22,  4, 1,2,32'h22,2,0,0);
        vt[9]  = mk(0,0,0,0,          0,0,0,0,             3, 1,32'h33,  4, 1,3,32'h33,3,0,0);
        vt[10] = mk(0,0,0,0,          0,0,0,0,             3, 0,0,       4, 0,0,0,0,0,0);
        vt[11] = mk(1,2,0,0,          0,0,0,0,             4, 0,0,       4, 0,0,0,0,0,0);
        vt[12] = mk(0,0,0,0,          1,4,0,0,             4, 1,0,       5, 1,0,0,4,1,0);
        vt[13] = mk(1,1,0,32'h100,    0,0,0,0,             5, 0,0,       5, 0,0,0,0,0,0);
        vt[14] = mk(0,0,0,0,          1,5,32'h40,32'h100,  5, 1,32'h40,  6, 1,0,32'h40,5,0,0);
        do_reset();
        for (int i = 0; i < 15; i++) apply(vt[i], i);

        // Fill all 16 entries, reject a 17th, then wrap after one retirement.
        do_reset();
        for (int i = 0; i < 16; i++) issue(2'd0, 5'(i + 1), 32'd0);
        chk("full rob_full", 32'(rob_full), 1);
        chk("full issue_tag", 32'(issue_tag), 0);
        issue(2'd0, 5'd31, 32'd0);
        chk("full17 rob_full", 32'(rob_full), 1);
        chk("full17 issue_tag", 32'(issue_tag), 0);
        wb(4'd0, 32'hAA, 32'd0);
        chk("full commit_signal", 32'(commit_signal), 1);
        chk("full commit_rd_id", 32'(commit_rd_id), 1);
        chk("full commit_rd_tag", 32'(commit_rd_tag), 0);
        chk("full after commit rob_full", 32'(rob_full), 0);
        chk("wrap issue_tag", 32'(issue_tag), 0);
        issue(2'd0, 5'd20, 32'd0);
        chk("wrap rob_full", 32'(rob_full), 1);
        chk("wrap next issue_tag", 32'(issue_tag), 1);

        // Mispredicted branch at head with younger entries in flight.
        do_reset();
        issue(2'd1, 5'd1, 32'h100);
        issue(2'd0, 5'd2, 32'd0);
        issue(2'd0, 5'd3, 32'd0);
        issue(2'd0, 5'd4, 32'd0);
        wb_signal = 1'b1; wb_tag = 4'd1; wb_value = 32'h77; query_tag_2 = 4'd1;
        #1;
        chk("br query_ready_2", 32'(query_ready_2), 1);
        chk("br query_value_2", query_value_2, 32'h77);
        tick();
        idle();
        wb(4'd0, 32'h4, 32'h200);
        chk("br commit_signal", 32'(commit_signal), 1);
        chk("br commit_rd_id", 32'(commit_rd_id), 1);
        chk("br commit_rd_tag", 32'(commit_rd_tag), 0);
        chk("br clear_signal", 32'(clear_signal), 1);
        chk("br clear_pc", clear_pc, 32'h200);
        chk("br issue_tag", 32'(issue_tag), 0);
        chk("br rob_full", 32'(rob_full), 0);
        query_tag_1 = 4'd1;
        #1;
        chk("br flushed query_ready", 32'(query_ready_1), 0);
        issue(2'd0, 5'd9, 32'd0);
        chk("br issue during clear", 32'(issue_tag), 0);
        chk("br clear deasserts", 32'(clear_signal), 0);
        chk("br commit deasserts", 32'(commit_signal), 0);
        issue(2'd0, 5'd9, 32'd0);
        chk("br post-flush issue", 32'(issue_tag), 1);

        // Global stall holds a ready head and the registered outputs.
        do_reset();
        issue(2'd0, 5'd10, 32'd0);
        issue(2'd0, 5'd11, 32'd0);
        wb(4'd1, 32'hB1, 32'd0);
        wb(4'd0, 32'hA0, 32'd0);
        chk("stall first commit_rd_tag", 32'(commit_rd_tag), 0);
        chk("stall first commit_rd_value", commit_rd_value, 32'hA0);
        rdy_in = 1'b0;
        issue_signal = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d commit_signal", k), 32'(commit_signal), 1);
            chk($sformatf("stall%0d commit_rd_tag", k), 32'(commit_rd_tag), 0);
            chk($sformatf("stall%0d issue_tag", k), 32'(issue_tag), 2);
        end
        rdy_in = 1'b1;
        idle();
        tick();
        chk("resume commit_signal", 32'(commit_signal), 1);
        chk("resume commit_rd_tag", 32'(commit_rd_tag), 1);
        chk("resume commit_rd_value", commit_rd_value, 32'hB1);
        chk("resume commit_rd_id", 32'(commit_rd_id), 11);
        tick();
        chk("resume pulse ends", 32'(commit_signal), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement stage of the out-of-order core. Entries are allocated at issue; each entry's index is its rename tag. Entries are marked ready by execution-unit write-back and retired at the head. This block drives the commit interface consumed by the register file, and it raises the pipeline-wide clear on a branch misprediction.

## Interface
- ROB_WIDTH, 4, tag width; depth = 2^ROB_WIDTH entries
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global stall; low freezes all state and registered outputs
- issue_signal  in  1  allocate the tail entry this cycle
- issue_type  in  2  0 = reg-write, 1 = branch/jump, 2 = store
- issue_rd_id  in  5  destination register; 0 = none
- issue_pred_pc  in  32  predicted next PC (branch type only)
- issue_tag  out  ROB_WIDTH  tag that the next issue receives (= tail)
- rob_full  out  1  count == 2^ROB_WIDTH (combinational)
- query_tag_1, query_tag_2  in  ROB_WIDTH  operand tags from issue
- query_ready_1, query_ready_2  out  1  entry holds a result
- query_value_1, query_value_2  out  32  result value
- wb_signal  in  1  execution result broadcast
- wb_tag  in  ROB_WIDTH  producing entry
- wb_value  in  32  rd value
- wb_next_pc  in  32  actual next PC (branch type only)
- commit_signal  out  1  one entry retired
- commit_rd_value  out  32  value of the retired entry
- commit_rd_id  out  5  destination; 0 when none
- commit_rd_tag  out  ROB_WIDTH  tag of the retired entry
- commit_store_signal  out  1  retired entry is a store; the LSB may perform it
- clear_signal  out  1  misprediction flush
- clear_pc  out  32  fetch redirect target; valid while clear_signal is high

## Operation
- Per-entry state: busy, ready, type, rd_id, value, pred_pc, next_pc. Pointers: head and tail (ROB_WIDTH bits, natural wrap). count is ROB_WIDTH+1 bits.
- Issue:
  - Accepted when issue_signal & ~rob_full & ~clear_signal.
  - Writes the tail entry (busy=1, ready=0). tail++, count++.
  - Issue while full is ignored.
- Write-back:
  - Applies when wb_signal and entry[wb_tag].busy.
  - Sets ready=1 and stores value and next_pc.
  - Write-back to a non-busy entry is ignored.
- Commit: when count != 0 and entry[head].ready:
  - Register commit_signal=1 and the head's rd_id/value/tag. Set commit_store_signal = (type==2).
  - Clear busy; head++, count--.
  - For branch type with next_pc != pred_pc: also set clear_signal=1 and clear_pc=next_pc. In the same cycle reset head=tail=count=0 and clear all busy bits.
- Query:
  - ready = busy & (ready | same-cycle wb match). value is forwarded from wb_value on a match.
  - Tags that are not busy report ready=0.
- Simultaneous issue and commit: count is unchanged. Both pointers advance.
- The register file performs the commit and the clear in the same cycle. A mispredicting JAL/JALR's rd is still committed.

## Timing
- All commit/clear outputs are registered. Each is a one-cycle pulse, deasserted the next active cycle unless a new retirement occurs.
- Write-back to commit latency:
  - The entry at head written in cycle N is committed with outputs visible in cycle N+1.
  - Throughput is one retirement per cycle.
- While clear_signal is high, issue_signal is ignored. The next issue after the flush receives tag 0.
- rdy_in low: no allocation, write-back, or commit. Outputs hold their values.
- Reset: all outputs 0 (rob_full=0, issue_tag=0). All busy=0; head=tail=count=0.
- Reset while entries are in flight discards them without a commit pulse.
- Wrap: tail 2^ROB_WIDTH-1 → 0 with no bubble. Full state has head == tail with count == 2^ROB_WIDTH.

## Structure
- Shared package `rob_pkg`:
  - Entry-type constants ROB_TYPE_REG=2'd0, ROB_TYPE_BR=2'd1, ROB_TYPE_ST=2'd2.
  - ROB_WIDTH default.
- Single module. Entry storage is per-field arrays. No sub-module is needed.

## Test plan
- Reset, then issue reg-write rd=5 → issue_tag 0. Then wb tag 0 value 0x1234 → next cycle commit_signal=1, rd_id=5, value=0x1234, tag=0.
- Out-of-order write-back: issue tags 0,1,2 (rd 1,2,3). wb order 2,1,0 → three consecutive commits in tag order 0,1,2.
- Fill 16 entries → rob_full=1 and a 17th issue is ignored. Commit one → rob_full=0. Next issue gets tag 0 (wrap).
- Branch tag 0 pred_pc 0x100, wb next_pc 0x200, with tags 1–3 in flight:
  - Commit pulse with clear_signal=1, clear_pc=0x200.
  - count becomes 0; the next issue gets tag 0.
  - A correctly predicted branch (next_pc 0x100) gives no clear.
- query_tag=3 with wb_tag=3 value 0xBEEF in the same cycle → query_ready=1, value=0xBEEF combinationally. Query of an empty tag → ready=0.
- Store entry retires → commit_store_signal=1, commit_rd_id=0. With rdy_in low for 3 cycles, a ready head is not committed until rdy_in returns.
